// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
// Default width, counter width and FSM state encoding.
package serial_add_pkg;

  localparam int WIDTH_DEF = 16;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_1bit.sv
// One-bit full adder used as the serial sum/carry cell.
// Ports: a, b, cin in; s (sum), cout (carry) out.
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_16bit.sv
// Bit-serial adder: a+b+cin over WIDTH cycles, LSB first.
// Ports: clk, rst_n, a, b, cin, start in; sum, cout, busy, done out.
// Define SERIAL_ADD_OVF_EN to add the registered ovf output.
module serial_adder_16bit
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             start,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_t st, st_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s;
  logic             co;
  logic             last;
  logic             accept;

  fa_1bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c),
    .s    (s),
    .cout (co)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = start && (st != BUSY);
  assign busy   = (st == BUSY);
  assign done   = (st == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (start) st_nx = BUSY;
      BUSY: if (last)  st_nx = DONE;
      DONE: st_nx = start ? BUSY : IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      cnt  <= '0;
      c    <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      c    <= cin;
      res  <= '0;
      cnt  <= '0;
    end else if (st == BUSY) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      c    <= co;
      res  <= {s, res[WIDTH-1:1]};
      // Counter parks on its last value; only a new start reloads it.
      if (last) begin
        sum  <= {s, res[WIDTH-1:1]};
        cout <= co;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // c is the carry into the MSB during the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ovf <= 1'b0;
    else if (!accept && busy && last) ovf <= c ^ co;
  end
`endif

endmodule

// File: tb/tb_serial_adder_16bit.sv
// Self-checking bench for serial_adder_16bit.
// Directed vectors plus a cycle-level reference model.
module tb_serial_adder_16bit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  serial_adder_16bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .start (start),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: result is plain arithmetic, appearing
  // WIDTH edges after the start is taken.
  int           rem = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] p_sum;
  logic         p_cout;
  logic         p_ovf;

  always @(negedge rst_n) begin
    rem = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (rem > 0) begin
        rem--;
        m_done = 1'b0;
        if (rem == 0) begin
          m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf; m_done = 1'b1;
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          {p_cout, p_sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
          p_ovf = (a[W-1] == b[W-1]) && (p_sum[W-1] != a[W-1]);
          rem = W;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_busy", {31'd0, busy}, {31'd0, rem > 0});
      chk("m_done", {31'd0, done}, {31'd0, m_done});
      chk("m_sum", {16'd0, sum}, {16'd0, m_sum});
      chk("m_cout", {31'd0, cout}, {31'd0, m_cout});
`ifdef SERIAL_ADD_OVF_EN
      chk("m_ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
    end
  end

  // Launch one op and wait for done; returns negedges to done.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, output int k);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (done) break;
    end
  endtask

  int k;
  int ndone;

  initial begin
    #2 rst_n = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("rst_sum", {16'd0, sum}, 32'h0);
    chk("rst_cout", {31'd0, cout}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'h0);

    run_op(16'h0001, 16'h00F0, 1'b1, k);
    chk("lat_f2", k, 17);
    chk("sum_f2", {16'd0, sum}, 32'h00F2);
    chk("cout_f2", {31'd0, cout}, 32'h0);

    run_op(16'hFFFF, 16'h0001, 1'b0, k);
    chk("sum_ffff", {16'd0, sum}, 32'h0000);
    chk("cout_ffff", {31'd0, cout}, 32'h1);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf_ffff", {31'd0, ovf}, 32'h0);
`endif

    run_op(16'h7FFF, 16'h0001, 1'b0, k);
    chk("sum_7fff", {16'd0, sum}, 32'h8000);
    chk("cout_7fff", {31'd0, cout}, 32'h0);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf_7fff", {31'd0, ovf}, 32'h1);
`endif
    @(negedge clk);
    chk("done_1cyc", {31'd0, done}, 32'h0);

    // Start re-pulsed mid-operation must be ignored.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 5) begin a = 16'h1234; start = 1'b1; end
      if (i == 2) chk("sum_hold", {16'd0, sum}, 32'h8000);
      if (done) begin
        ndone++;
        if (ndone == 1) chk("lat_ign", i, 17);
      end
    end
    chk("ndone_ign", ndone, 1);
    chk("sum_ign", {16'd0, sum}, 32'h3333);

    // Reset mid-operation aborts.
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_sum", {16'd0, sum}, 32'h0);
    chk("abort_cout", {31'd0, cout}, 32'h0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_ndone", ndone, 0);

    // Start held through DONE: back-to-back with no IDLE gap.
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; cin = 1'b0; start = 1'b1;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      a = 16'h0003; b = 16'h0030;
      if (done) break;
    end
    chk("lat_b2b", k, 17);
    chk("sum_b2b0", {16'd0, sum}, 32'h0030);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("b2b_busy", {31'd0, busy}, 32'h1);
      start = 1'b0;
      if (done) break;
    end
    chk("lat_b2b1", k, 17);
    chk("sum_b2b1", {16'd0, sum}, 32'h0033);

    repeat (3) @(negedge clk);
    chk("end_idle", {31'd0, busy | done}, 32'h0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_adder_16bit.md
SERIAL_ADDER_16BIT -- requirements
Module: serial_adder_16bit

Interface
REQ-001 SHALL have parameter WIDTH, default 16; operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port a, input, WIDTH, addend A, sampled only when a start is accepted.
REQ-005 SHALL have port b, input, WIDTH, addend B, sampled only when a start is accepted.
REQ-006 SHALL have port cin, input, 1, carry-in, sampled only when a start is accepted.
REQ-007 SHALL have port start, input, 1, request to begin an addition.
REQ-008 SHALL have port sum, output, WIDTH, registered result of a+b+cin modulo 2^WIDTH.
REQ-009 SHALL have port cout, output, 1, registered carry-out of bit WIDTH-1.
REQ-010 SHALL have port busy, output, 1, high while bits are being processed.
REQ-011 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-012 SHALL implement the three states IDLE, BUSY and DONE.
REQ-013 SHALL accept start in IDLE or DONE: at that edge load a, b and cin into internal shift/carry registers, clear the bit counter, and enter BUSY.
REQ-014 SHALL ignore start while in BUSY, with no operand reload and no effect on the counter.
REQ-015 SHALL, in BUSY, process one bit per cycle LSB-first, shifting the sum bit into the internal result register and registering the carry.
REQ-016 SHALL, after WIDTH BUSY edges, copy the result into sum and the final carry into cout, and enter DONE.
REQ-017 SHALL make done valid for exactly one cycle: start accepted at edge 0 gives done=1 in the cycle following edge WIDTH (WIDTH-cycle latency).
REQ-018 SHALL drive busy=1 from the cycle after the accepting edge through the cycle containing edge WIDTH, and busy=0 in DONE and IDLE.
REQ-019 SHALL go from DONE to IDLE on the next edge when start=0, or to BUSY when start=1 (back-to-back operation).
REQ-020 SHALL hold sum and cout stable from one completion until the next completion; they SHALL NOT change during BUSY.
REQ-021 SHALL use a counter of ceil(log2(WIDTH)) bits that wraps only by reload on start, never free-running.

Reset
REQ-022 SHALL, with rst_n=0, asynchronously force state=IDLE, sum=0, cout=0, busy=0, done=0, counter=0 and internal registers=0.
REQ-023 SHALL abort any operation in progress when reset asserts mid-operation: no done pulse, and sum/cout read 0.
REQ-024 SHALL remain in IDLE after rst_n deasserts until the first start.

Configuration
REQ-025 SHALL, with macro SERIAL_ADD_OVF_EN defined, add output port ovf (1 bit) equal to the signed overflow (carry into MSB XOR carry out), registered and held exactly like cout, with reset value 0.
REQ-026 SHALL, without SERIAL_ADD_OVF_EN, omit both the ovf port and its logic entirely.

Structure
REQ-027 SHALL take WIDTH default, the counter width constant and the state enumeration from shared package serial_add_pkg.
REQ-028 SHALL instantiate the per-bit sum/carry as sub-module fa_1bit (inputs a, b, cin; outputs s, cout).

Verification
REQ-029 SHALL cover: a=0001, b=00F0, cin=1, start -> done after 16 cycles, sum=00F2, cout=0.
REQ-030 SHALL cover: a=FFFF, b=0001, cin=0 -> sum=0000, cout=1, ovf=0 when enabled.
REQ-031 SHALL cover: a=7FFF, b=0001, cin=0 -> sum=8000, cout=0, ovf=1 when enabled.
REQ-032 SHALL cover: start pulsed again with a=1234 at BUSY cycle 5 -> ignored; the result matches the first operands and exactly one done pulse occurs.
REQ-033 SHALL cover: rst_n low at BUSY cycle 8 -> busy=0 immediately, no done pulse, sum=0000, cout=0.
REQ-034 SHALL cover: start held high through DONE with a=0003, b=0030 -> a new BUSY begins with no IDLE cycle, and the next result is 0033.
